// File: rtl/nl2_cln_arb_slice_if.sv
// N-request-port packet arbiter bundle: per-port in_* requests, one registered out_* stream.
// Latency: none (signal bundle only).
// Backpressure: in_ready driven by the arbiter, out_ready driven by the downstream consumer.
interface nl2_cln_arb_slice_if #(
    parameter int N    = 2,
    parameter int DW   = 32,
    parameter int ADDR = $clog2(N)
);
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [ADDR-1:0] out_src;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/nl2_cln_arb_slice.sv
// Packet-locked round-robin arbiter of N request ports into one registered output beat.
// Latency: accepted beat appears on out_* one cycle later; full throughput.
// Backpressure: in_ready only when the output register can load (!out_valid || out_ready).
module nl2_cln_arb_slice #(
    parameter int N    = 2,
    parameter int DW   = 32,
    parameter int ADDR = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_a,
    nl2_cln_arb_slice_if.slave bus
);
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ADDR-1:0] r_pivot;
    logic [ADDR-1:0] w_pivot_nxt;
    logic [ADDR-1:0] r_grant;
    logic [ADDR-1:0] w_grant_nxt;

    logic            w_load_en;
    logic            w_cand_vld;
    logic [ADDR-1:0] w_cand;
    logic [ADDR-1:0] w_sel;
    logic            w_sel_vld;
    logic            w_sel_last;
    logic [DW-1:0]   w_sel_data;
    logic            w_xfer;
    logic [N-1:0]    w_ready;

    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;
    logic            r_out_last;
    logic [ADDR-1:0] r_out_src;

    assign w_load_en = !r_out_valid || bus.out_ready;

    // Rotating priority: lowest valid port above the pivot wins, else wrap to the lowest at/below it.
    always_comb begin
        w_cand_vld = 1'b0;
        w_cand     = '0;
        // Descending scans so the lowest index is the last (winning) write; the
        // above-pivot scan runs second so it overrides any wrap-around choice.
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.in_valid[i] && (ADDR'(i) <= r_pivot)) begin
                w_cand_vld = 1'b1;
                w_cand     = ADDR'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.in_valid[i] && (ADDR'(i) > r_pivot)) begin
                w_cand_vld = 1'b1;
                w_cand     = ADDR'(i);
            end
        end
    end

    // Beat mux: the locked owner while a packet is open, otherwise the new candidate.
    always_comb begin
        w_sel      = (r_state == ST_LOCKED) ? r_grant : w_cand;
        w_sel_vld  = 1'b0;
        w_sel_last = 1'b0;
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (ADDR'(i) == w_sel) begin
                w_sel_vld  = bus.in_valid[i];
                w_sel_last = bus.in_last[i];
                w_sel_data = bus.in_data[i*DW +: DW];
            end
        end
    end

    // Next-state, pivot/grant update and one-hot ready generation.
    always_comb begin
        w_state_nxt = r_state;
        w_pivot_nxt = r_pivot;
        w_grant_nxt = r_grant;
        w_ready     = '0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cand_vld && w_load_en) begin
                    w_ready[w_cand] = 1'b1;
                    w_xfer          = 1'b1;
                    if (w_sel_last) begin
                        w_pivot_nxt = w_cand;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                        w_grant_nxt = w_cand;
                    end
                end
            end
            ST_LOCKED: begin
                // A gap on the owner keeps the lock; nobody else is offered a slot.
                w_ready[r_grant] = w_load_en;
                if (w_load_en && w_sel_vld) begin
                    w_xfer = 1'b1;
                    if (w_sel_last) begin
                        w_state_nxt = ST_IDLE;
                        w_pivot_nxt = r_grant;
                    end
                end
            end
        endcase
        // Reset is asynchronous, so ready must drop with it rather than wait for an edge.
        if (!rst_a) begin
            w_ready = '0;
        end
    end

    // Arbitration state; pivot starts at N-1 so port 0 is first after reset.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_state <= ST_IDLE;
            r_pivot <= ADDR'(N - 1);
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pivot <= w_pivot_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Output register: payload only moves on a transfer, valid drops on an unrefilled drain.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= w_sel_last;
            r_out_src   <= w_sel;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_src   = r_out_src;
endmodule

// File: doc/nl2_cln_arb_slice.md
NL2_CLN_ARB_SLICE -- requirements
Module: nl2_cln_arb_slice

Interface
REQ-001 Parameters SHALL be: N, default 2, number of request ports (N>=2); DW, default 32, payload width; ADDR, default $clog2(N), source-index width.
REQ-002 Port clk, input, 1, the single clock; all state SHALL be rising-edge clocked.
REQ-003 Port rst_a, input, 1, reset SHALL be asynchronous and active-low.
REQ-004 Port in_valid, input, N, per-port beat valid.
REQ-005 Port in_ready, output, N, per-port beat accept.
REQ-006 Port in_data, input, N*DW, port i payload at bits [i*DW +: DW].
REQ-007 Port in_last, input, N, per-port last beat of packet.
REQ-008 Port out_valid, input/output as named: output, 1, registered beat valid.
REQ-009 Port out_ready, input, 1, downstream accept.
REQ-010 Port out_data, output, DW, registered payload.
REQ-011 Port out_last, output, 1, registered last flag.
REQ-012 Port out_src, output, ADDR, index of the port that supplied the registered beat.

Function
REQ-013 Handshake: a beat transfers on a port when valid and ready are both high at a rising edge; inputs SHALL hold valid/data/last stable until accepted.
REQ-014 Output stage: single register; load_en = !out_valid || out_ready; full throughput SHALL be sustained (unload and reload in the same cycle).
REQ-015 Latency: an accepted input beat SHALL appear on out_* exactly 1 cycle later.
REQ-016 State machine: IDLE and LOCKED, plus registered pivot (ADDR bits) and grant index (ADDR bits).
REQ-017 IDLE: candidate = lowest-index valid port strictly above pivot, else lowest-index valid port at or below pivot (wrap-around); no valid port -> no candidate.
REQ-018 IDLE with candidate c and load_en: in_ready[c]=1 only; on transfer, if in_last[c]=1 stay IDLE and set pivot=c, else go LOCKED with grant=c.
REQ-019 LOCKED: in_ready[grant]=load_en; all other in_ready SHALL be 0; gaps (in_valid[grant]=0) SHALL hold the lock.
REQ-020 LOCKED: on a transfer with in_last[grant]=1, go IDLE and set pivot=grant in the same edge.
REQ-021 in_ready SHALL be one-hot or zero in every cycle; in_ready SHALL be 0 on every port while load_en=0.
REQ-022 in_ready MAY depend combinationally on in_valid and out_ready; out_* SHALL be register outputs only.
REQ-023 out_data/out_last/out_src SHALL change only on a transfer; they hold when out_valid=1 and out_ready=0.
REQ-024 out_valid SHALL be set on any input transfer and cleared on an out_ready handshake with no simultaneous input transfer.
REQ-025 Simultaneous requests on every port SHALL be served one packet per port in rotating index order, no port starved.

Reset
REQ-026 While rst_a=0: out_valid=0, out_data=0, out_last=0, out_src=0, state=IDLE, pivot=N-1, in_ready=0.
REQ-027 Reset asserted mid-packet SHALL discard the lock and any registered beat; after release, first grant SHALL go to the lowest-index valid port.
REQ-028 Reset assertion SHALL take effect without a clock edge; release SHALL be synchronised externally.

Verification
REQ-029 N=2: reset, then in_valid=2'b11, both last=1, out_ready=1 -> out_src sequence 0,1,0,1 on consecutive cycles, out_valid continuously 1 from cycle 2.
REQ-030 Port 0 sends 3-beat packet (last on beat 3) while port 1 valid -> out_src=0,0,0 then 1; in_ready[1]=0 throughout the port 0 packet.
REQ-031 Backpressure: out_ready=0 for 4 cycles with beat held -> out_data stable, in_ready=0 all ports; release -> next beat the following cycle, no beat lost or duplicated.
REQ-032 Lock gap: port 1 mid-packet drops in_valid for 2 cycles while port 0 valid -> no port 0 beat issued until port 1 last accepted.
REQ-033 N=4, only ports 1 and 3 valid, pivot=3 after a port 3 packet -> next grant port 1, then port 3.
REQ-034 Reset asserted while LOCKED with out_valid=1 -> out_valid=0 immediately; after release with in_valid=4'b1100 -> first out_src=2.
